// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state encoding for the sequential divider
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 3;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = {DIV_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on unsigned magnitudes
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < dmag on entry, so the extra bit of diff is a clean borrow flag
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dmag};
  assign rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - iterative signed divider, one restoring step per clock
// DIV32_ZERO_BYPASS_EN: a zero divisor skips the iterations (LOAD -> FIX).
module div32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] dvd_r, dvs_r, rem_r, quo_r, dmag_r;
  logic [WIDTH-1:0] rem_step, quo_step, quo_fix, rem_fix;
  logic [CW-1:0]    cnt_r;
  logic             neg_q_r, neg_r_r, zero_r;
  logic             dvs_zero;

  assign dvs_zero = (dvs_r == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_r),
    .quo     (quo_r),
    .dmag    (dmag_r),
    .rem_nxt (rem_step),
    .quo_nxt (quo_step)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
`ifdef DIV32_ZERO_BYPASS_EN
      S_LOAD: state_nxt = dvs_zero ? S_FIX : S_CALC;
`else
      S_LOAD: state_nxt = S_CALC;
`endif
      S_CALC: if (cnt_r == CW'(1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Magnitude negation wraps 0x80..0 onto itself, which reads correctly as unsigned 2^(WIDTH-1)
  always_comb begin
    quo_fix = zero_r ? {WIDTH{1'b1}} : (neg_q_r ? -quo_r : quo_r);
    rem_fix = zero_r ? dvd_r : (neg_r_r ? -rem_r : rem_r);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      dvd_r     <= '0;
      dvs_r     <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dmag_r    <= '0;
      cnt_r     <= '0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      zero_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          dvd_r   <= dividend;
          dvs_r   <= divisor;
          neg_r_r <= dividend[WIDTH-1];
          neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        end
        S_LOAD: begin
          rem_r  <= '0;
          quo_r  <= dvd_r[WIDTH-1] ? -dvd_r : dvd_r;
          dmag_r <= dvs_r[WIDTH-1] ? -dvs_r : dvs_r;
          cnt_r  <= CW'(WIDTH);
          zero_r <= dvs_zero;
        end
        S_CALC: begin
          rem_r <= rem_step;
          quo_r <= quo_step;
          cnt_r <= cnt_r - CW'(1);
        end
        S_FIX: begin
          quotient  <= quo_fix;
          remainder <= rem_fix;
          div_zero  <= zero_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - randomized self-checking bench for div32_seq against an arithmetic model
module tb_div32_seq;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        nRst;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

`ifdef DIV32_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = DIV_LATENCY - 1;
`endif
  localparam int FULL_LAT = DIV_LATENCY - 1;

  always #5 clk = ~clk;

  div32_seq #(.WIDTH(DIV_WIDTH)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Truncating signed division; the wrap case is spelled out so host overflow rules never apply
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    int sa, sb;
    sa = a;
    sb = b;
    z  = 1'b0;
    if (sb == 0) begin
      q = DIV_ZERO_QUO; r = a; z = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0;
    end else begin
      q = sa / sb; r = sa % sb;
    end
  endfunction

  // Starts one operation and waits for done; lat counts negedges after the accepting edge
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hammer,
                        output int lat, output bit busy_ok);
    bit seen;
    seen    = 1'b0;
    busy_ok = 1'b1;
    lat     = -1;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end
      start = hammer;
      if (hammer) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
    end
    if (!seen) check("timeout", 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic verify(input string tag, input logic [31:0] a, input logic [31:0] b, input bit hammer);
    logic [31:0] eq, er;
    logic        ez;
    int          lat;
    bit          bok;
    run_op(a, b, hammer, lat, bok);
    ref_div(a, b, eq, er, ez);
    // run_op returns one cycle after done, so these results must already be held in IDLE
    check({tag, ".quo"}, quotient, eq);
    check({tag, ".rem"}, remainder, er);
    check({tag, ".dz"}, {31'd0, div_zero}, {31'd0, ez});
    check({tag, ".lat"}, lat, (b == 32'd0) ? ZERO_LAT : FULL_LAT);
    check({tag, ".busy"}, {31'd0, bok}, 32'd1);
    check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  logic [31:0] da [8] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000,
                          32'h8000_0000, 32'h1234_5678, 32'd0, 32'h7FFF_FFFF};
  logic [31:0] db [8] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                          32'd2, 32'd0, 32'd5, 32'h8000_0000};

  initial begin
    int extra, k_rst;
    logic [31:0] a, b, hq, hr;
    bit got_done;
    nRst = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.quo", quotient, 32'd0);
    check("rst.rem", remainder, 32'd0);
    check("rst.dz", {31'd0, div_zero}, 32'd0);
    nRst = 1'b1;
    @(negedge clk);

    check("pkg.zq", DIV_ZERO_QUO, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) verify($sformatf("dir%0d", i), da[i], db[i], 1'b0);

    // Start held high and operands churned throughout: one done, original operands used
    verify("ham", 32'd100, 32'd7, 1'b1);
    hq = quotient;
    hr = remainder;
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ham.extra", extra, 32'd0);
    check("ham.hold.quo", quotient, hq);
    check("ham.hold.rem", remainder, hr);

    // Reset ten cycles into an operation
    @(negedge clk);
    dividend = 32'h1234_5678;
    divisor  = 32'h0000_1234;
    start    = 1'b1;
    @(posedge clk);
    k_rst = 0;
    got_done = 1'b0;
    while (k_rst < 10) begin
      @(negedge clk);
      start = 1'b0;
      if (done) got_done = 1'b1;
      k_rst++;
    end
    nRst = 1'b0;
    #1;
    check("mid.busy", {31'd0, busy}, 32'd0);
    check("mid.quo", quotient, 32'd0);
    check("mid.rem", remainder, 32'd0);
    check("mid.dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    nRst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    check("mid.nodone", {31'd0, got_done}, 32'd0);
    verify("restart", 32'h1234_5678, 32'h0000_1234, 1'b0);

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = -$urandom_range(1, 255);
        default: b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      endcase
      verify($sformatf("rnd%0d", i), a, b, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
